// File: rtl/bram_stream_reader_pkg.sv
// Shared constants and state encoding for the BRAM stream reader and the
// 32x4 block RAM it reads from.
package bram_stream_reader_pkg;

  localparam int BRAM_DEPTH  = 32;
  localparam int BRAM_ADDR_W = $clog2(BRAM_DEPTH);
  localparam int BRAM_DATA_W = 4;
  localparam int BRAM_LEN_W  = BRAM_ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// BRAM read port plus the outgoing valid/ready word stream of the reader.
interface bram_stream_reader_if
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_r_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output mem_addr, mem_we, out_valid, out_data, out_last,
    input  mem_r_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_we, out_valid, out_data, out_last,
    output mem_r_data, out_ready
  );
endinterface

// File: rtl/bram_stream_reader_fifo.sv
// Two-entry FIFO of {last, data} that absorbs BRAM read latency and
// downstream backpressure; the producer must never push when full.
module stream_skid_fifo2 #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [1:0]        count
);
  logic [DATA_W-1:0] data_q [2];
  logic              last_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is data only; emptiness is tracked by count_q, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= push_data;
      last_q[wr_ptr_q] <= push_last;
    end
  end

  assign count     = count_q;
  assign head_data = (count_q != 2'd0) ? data_q[rd_ptr_q] : '0;
  assign head_last = (count_q != 2'd0) && last_q[rd_ptr_q];
endmodule

// File: rtl/bram_stream_reader.sv
// Walks a contiguous BRAM address range on a start command and streams the
// words out on a valid/ready interface with no loss or duplication.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W,
  parameter int LEN_W  = BRAM_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [LEN_W-1:0]     length,
  output logic                 busy,
  output logic                 done,
  bram_stream_reader_if.master bus
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic              rd_vld_p1;
  logic              rd_last_p1;
  logic              done_q;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_last;
  logic [2:0]        credit_use;
  logic              pop;
  logic              issue;
  logic              accept;
  logic              accept_empty;
  logic              final_issue;

  assign pop          = bus.out_valid && bus.out_ready;
  // A pop in this cycle frees its slot before the new read's data lands.
  assign credit_use   = {1'b0, fifo_count} + {2'b00, rd_vld_p1} - {2'b00, pop};
  assign issue        = (state_q == ST_RUN) && (credit_use < 3'd2);
  assign final_issue  = issue && (remain_q == LEN_ONE);
  assign accept       = (state_q == ST_IDLE) && start && (length != '0);
  assign accept_empty = (state_q == ST_IDLE) && start && (length == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (final_issue) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && bus.out_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // p0: read issue / address and length bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= base_addr;
        remain_q <= length;
      end else if (issue) begin
        addr_q   <= addr_q + ADDR_ONE;
        remain_q <= remain_q - LEN_ONE;
      end
      rd_vld_p1  <= issue;
      rd_last_p1 <= final_issue;
      done_q     <= accept_empty || ((state_q == ST_DRAIN) && pop && bus.out_last);
    end
  end

  // p1: BRAM data returns and is captured into the buffer
  stream_skid_fifo2 #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_vld_p1),
    .push_data (bus.mem_r_data),
    .push_last (rd_last_p1),
    .pop       (pop),
    .head_data (fifo_data),
    .head_last (fifo_last),
    .count     (fifo_count)
  );

  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = 1'b0;
  assign bus.out_valid = (fifo_count != 2'd0);
  assign bus.out_data  = fifo_data;
  assign bus.out_last  = fifo_last;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: directed bursts push expected
// words into a queue; a negedge monitor pops and compares on each handshake.
module tb_bram_stream_reader;
  import bram_stream_reader_pkg::*;

  typedef struct packed {
    logic       last;
    logic [3:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] length;
  logic       busy;
  logic       done;

  bram_stream_reader_if bus ();

  bram_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  logic [3:0] mem [32];
  exp_t       exp_q [$];
  int         n_chk;
  int         n_fail;
  int         addr_hist [8];
  bit         prev_stall;
  logic [3:0] prev_data;
  logic       prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM model
  always @(posedge clk) bus.mem_r_data <= mem[bus.mem_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", int'(bus.out_valid), 1);
        chk("stall_data_stable", int'(bus.out_data), int'(prev_data));
        chk("stall_last_stable", int'(bus.out_last), int'(prev_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        exp_t e;
        chk("word_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", int'(bus.out_data), int'(e.data));
          chk("out_last", int'(bus.out_last), int'(e.last));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic do_start(input int base, input int len, input bit expect_words);
    exp_t e;
    start     = 1'b1;
    base_addr = base[4:0];
    length    = len[5:0];
    if (expect_words) begin
      for (int i = 0; i < len; i++) begin
        e.data = mem[(base + i) % 32];
        e.last = (i == len - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Entered just after the edge that sampled start; returns at the done negedge.
  task automatic run_burst(input logic [63:0] rpat, input int inj_k, input int base,
                           output int done_lat, output int first_lat,
                           output bit busy_ok, output int max_ahead);
    int acc;
    int a;
    acc       = 0;
    done_lat  = -1;
    first_lat = -1;
    busy_ok   = 1'b1;
    max_ahead = 0;
    bus.out_ready = rpat[1];
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      if (k <= 8) addr_hist[k-1] = int'(bus.mem_addr);
      a = ((int'(bus.mem_addr) - base + 32) % 32) - acc;
      if (a > max_ahead) max_ahead = a;
      if (bus.out_valid && first_lat < 0) first_lat = k - 1;
      if (done) begin
        done_lat = k - 1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (bus.out_valid && bus.out_ready) acc++;
      @(posedge clk);
      #1;
      bus.out_ready = rpat[(k + 1) % 64];
      start = (k + 1 == inj_k);
      if (start) begin
        base_addr = 5'd20;
        length    = 6'd3;
      end
    end
    if (done_lat < 0) $display("FAIL burst_timeout: got no done, required done within 400 cycles");
  endtask

  int         dl, fl, ma;
  bit         bo;
  int         acc5;
  logic [63:0] ones;

  initial begin
    n_chk = 0;
    n_fail = 0;
    prev_stall = 1'b0;
    ones = '1;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) mem[i] = i[3:0];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic burst
    do_start(0, 4, 1'b1);
    run_burst(ones, -1, 0, dl, fl, bo, ma);
    chk("t1_done_latency", dl, 6);
    chk("t1_first_valid_latency", fl, 2);
    chk("t1_busy_throughout", int'(bo), 1);
    chk("t1_busy_at_done", int'(busy), 0);
    chk("t1_queue_empty", exp_q.size(), 0);

    // 2: address wrap
    @(posedge clk);
    #1;
    do_start(30, 4, 1'b1);
    run_burst(ones, -1, 30, dl, fl, bo, ma);
    chk("t2_addr0", addr_hist[0], 30);
    chk("t2_addr1", addr_hist[1], 31);
    chk("t2_addr2", addr_hist[2], 0);
    chk("t2_addr3", addr_hist[3], 1);
    chk("t2_done_latency", dl, 6);
    chk("t2_queue_empty", exp_q.size(), 0);

    // 3: backpressure with a 5-cycle stall
    @(posedge clk);
    #1;
    do_start(8, 8, 1'b1);
    run_burst(64'hFFFF_FFFF_FFFF_F833, -1, 8, dl, fl, bo, ma);
    chk("t3_max_reads_ahead", ma, 2);
    chk("t3_busy_throughout", int'(bo), 1);
    chk("t3_queue_empty", exp_q.size(), 0);
    bus.out_ready = 1'b1;

    // 4a: zero-length burst
    @(posedge clk);
    #1;
    do_start(7, 0, 1'b0);
    @(negedge clk);
    chk("t4_len0_done", int'(done), 1);
    chk("t4_len0_busy", int'(busy), 0);
    chk("t4_len0_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("t4_len0_done_single", int'(done), 0);
    chk("t4_len0_busy_after", int'(busy), 0);
    chk("t4_len0_valid_after", int'(bus.out_valid), 0);

    // 4b: full-depth burst with wrap
    @(posedge clk);
    #1;
    do_start(5, 32, 1'b1);
    run_burst(ones, -1, 5, dl, fl, bo, ma);
    chk("t4_len32_done_latency", dl, 34);
    chk("t4_len32_queue_empty", exp_q.size(), 0);

    // 5: reset mid-burst after the third word
    @(posedge clk);
    #1;
    do_start(0, 8, 1'b1);
    acc5 = 0;
    for (int k = 0; k < 50 && acc5 < 3; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) acc5++;
    end
    chk("t5_three_words_seen", acc5, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_valid", int'(bus.out_valid), 0);
    chk("t5_abort_busy", int'(busy), 0);
    chk("t5_abort_done", int'(done), 0);
    chk("t5_abort_mem_addr", int'(bus.mem_addr), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("t5_no_done_in_reset", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(2, 2, 1'b1);
    run_burst(ones, -1, 2, dl, fl, bo, ma);
    chk("t5_restart_done_latency", dl, 4);
    chk("t5_restart_queue_empty", exp_q.size(), 0);

    // 6: ignored start while busy, then back-to-back start in the done cycle
    @(posedge clk);
    #1;
    do_start(0, 4, 1'b1);
    run_burst(ones, 2, 0, dl, fl, bo, ma);
    chk("t6_done_latency", dl, 6);
    chk("t6_busy_throughout", int'(bo), 1);
    do_start(10, 3, 1'b1);
    run_burst(ones, -1, 10, dl, fl, bo, ma);
    chk("t6_chained_done_latency", dl, 5);
    chk("t6_chained_first_valid", fl, 2);
    chk("t6_queue_empty", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("t6_idle_no_stray_valid", int'(bus.out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
